// File: rtl/toccata_volume_ramp.sv
// ---------------------------------------------------------------------------
// toccata_volume_ramp
//
// Per-channel attenuation sequencer between the Toccata register file and the
// toccata_volume datapath. Host writes set a target attenuation and a mute
// bit per channel. The applied attenuation then walks toward the effective
// target one step at a time. A step is taken only on an audio zero crossing,
// or after ZC_TIMEOUT strobes without one. Consecutive steps are separated by
// STEP_DIV strobes of hold. Power-up output is fully attenuated (silent).
//
// Ports
//   clk                clock
//   rst                synchronous, active-high reset
//   sample_strobe      one-cycle pulse per audio sample; audio_in_* valid
//   audio_in_left      signed left sample, used for zero-cross detection
//   audio_in_right     signed right sample, used for zero-cross detection
//   reg_wr             register write strobe
//   reg_addr           0 = left channel, 1 = right channel
//   reg_wdata          [ATT_W] = mute, [ATT_W-1:0] = target attenuation
//   attenuation_left   applied left attenuation
//   attenuation_right  applied right attenuation
//   busy               high while either channel is not IDLE
//   ramp_done_left     one-cycle pulse when the left channel returns to IDLE
//   ramp_done_right    one-cycle pulse when the right channel returns to IDLE
//
// Channel FSM (one per channel, identical)
//   state   | meaning
//   IDLE    | attenuation equals effective target, nothing to do
//   WAIT_ZC | waiting for a zero crossing (or timeout) to take one step
//   HOLD    | minimum spacing after a step before the next may be taken
// ---------------------------------------------------------------------------
module toccata_volume_ramp #(
    parameter int ATT_W      = 6,
    parameter int STEP_DIV   = 16,
    parameter int ZC_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_strobe,
    input  logic signed [15:0] audio_in_left,
    input  logic signed [15:0] audio_in_right,
    input  logic               reg_wr,
    input  logic               reg_addr,
    input  logic [ATT_W:0]     reg_wdata,
    output logic [ATT_W-1:0]   attenuation_left,
    output logic [ATT_W-1:0]   attenuation_right,
    output logic               busy,
    output logic               ramp_done_left,
    output logic               ramp_done_right
);

    localparam logic [ATT_W-1:0] ATT_MAX = {ATT_W{1'b1}};

    // Timers are down-counters loaded with their terminal distance and
    // compared against zero; a width of at least one bit keeps the degenerate
    // parameter value of 1 legal.
    localparam int ZW = (ZC_TIMEOUT > 1) ? $clog2(ZC_TIMEOUT) : 1;
    localparam int HW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [ZW-1:0] ZC_LAST   = ZW'(ZC_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ZC = 2'd1,
        HOLD    = 2'd2
    } state_t;

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        localparam logic CH_ADDR = 1'(ch);

        logic signed [15:0] audio;
        logic               wr_sel;
        logic [ATT_W-1:0]   target;
        logic               mute;
        logic [ATT_W-1:0]   eff_target;
        logic               prev_sign;
        logic               zc;
        logic               at_target;
        logic               step_up;
        logic               idle;
        state_t             state;
        logic [ATT_W-1:0]   attenuation;
        logic [ZW-1:0]      zc_cnt;
        logic [HW-1:0]      hold_cnt;
        logic               ramp_done;

        assign audio  = (ch == 0) ? audio_in_left : audio_in_right;
        assign wr_sel = reg_wr && (reg_addr == CH_ADDR);

        // Target/mute registers. The FSM below reads the registered values,
        // so a write only influences stepping from the following cycle on.
        always_ff @(posedge clk) begin
            if (rst) begin
                target <= ATT_MAX;
                mute   <= 1'b0;
            end else if (wr_sel) begin
                target <= reg_wdata[ATT_W-1:0];
                mute   <= reg_wdata[ATT_W];
            end
        end

        assign eff_target = mute ? ATT_MAX : target;
        assign at_target  = (attenuation == eff_target);
        // Direction is re-derived at every step, so a reversal of the target
        // mid-ramp turns around on the very next step without overshoot.
        assign step_up    = (eff_target > attenuation);

        // Only the sign of the previous sample matters for crossing detection.
        assign zc   = (audio == 16'sd0) || (audio[15] != prev_sign);
        assign idle = (state == IDLE);

        always_ff @(posedge clk) begin
            if (rst) begin
                state       <= IDLE;
                attenuation <= ATT_MAX;
                zc_cnt      <= '0;
                hold_cnt    <= '0;
                ramp_done   <= 1'b0;
                prev_sign   <= 1'b0;
            end else begin
                ramp_done <= 1'b0;

                if (sample_strobe) begin
                    prev_sign <= audio[15];
                end

                case (state)
                    IDLE: begin
                        if (!at_target) begin
                            state  <= WAIT_ZC;
                            zc_cnt <= ZC_LAST;
                        end
                    end

                    WAIT_ZC: begin
                        if (at_target) begin
                            state     <= IDLE;
                            ramp_done <= 1'b1;
                        end else if (sample_strobe) begin
                            if (zc || (zc_cnt == '0)) begin
                                // at_target is false here, so the step never
                                // leaves the 0..ATT_MAX range.
                                attenuation <= step_up ? attenuation + 1'b1
                                                       : attenuation - 1'b1;
                                state       <= HOLD;
                                hold_cnt    <= HOLD_LAST;
                            end else begin
                                zc_cnt <= zc_cnt - 1'b1;
                            end
                        end
                    end

                    HOLD: begin
                        // The hold length is fixed once entered; target writes
                        // are only looked at when it expires.
                        if (sample_strobe) begin
                            if (hold_cnt == '0) begin
                                if (at_target) begin
                                    state     <= IDLE;
                                    ramp_done <= 1'b1;
                                end else begin
                                    state  <= WAIT_ZC;
                                    zc_cnt <= ZC_LAST;
                                end
                            end else begin
                                hold_cnt <= hold_cnt - 1'b1;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign attenuation_left  = g_chan[0].attenuation;
    assign attenuation_right = g_chan[1].attenuation;
    assign ramp_done_left    = g_chan[0].ramp_done;
    assign ramp_done_right   = g_chan[1].ramp_done;
    assign busy              = !g_chan[0].idle || !g_chan[1].idle;

endmodule

// File: doc/toccata_volume_ramp.md
Name: toccata_volume_ramp

Overview:
Per-channel attenuation sequencer sitting between the Toccata register file and the toccata_volume datapath. It accepts host target-attenuation and mute writes, then drives attenuation_left/right one step at a time. Steps occur only at audio zero crossings, or after a timeout, and are separated by a minimum hold. This removes zipper noise and pops from volume changes and from power-up.

Parameters:
ATT_W, 6, attenuation width; max attenuation ATT_MAX = 2**ATT_W-1 (63)
STEP_DIV, 16, sample strobes held after each step before the next step may be taken (>=1)
ZC_TIMEOUT, 64, sample strobes waited for a zero crossing before a forced step (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sample_strobe  in  1  one-cycle pulse per audio sample; audio_in_* are valid on this cycle
audio_in_left  in  16  signed left sample, used for zero-cross detection
audio_in_right  in  16  signed right sample
reg_wr  in  1  register write strobe
reg_addr  in  1  0 = left, 1 = right
reg_wdata  in  7  bit6 = mute, bits5:0 = target attenuation
attenuation_left  out  6  applied left attenuation, to toccata_volume
attenuation_right  out  6  applied right attenuation
busy  out  1  high while either channel is not IDLE
ramp_done_left  out  1  one-cycle pulse when the left channel returns to IDLE
ramp_done_right  out  1  one-cycle pulse when the right channel returns to IDLE

Behaviour:
- Reset values: attenuation_* = 63, target_* = 63, mute_* = 0, both FSMs IDLE, busy = 0, ramp_done_* = 0, prev_sample_* = 0, counters = 0. Power-up output is silent.
- Write handling: on reg_wr, the selected channel's target and mute registers update at the clock edge. The FSM step logic in the same cycle uses the pre-write values.
- eff_target = mute ? 63 : target.
- Zero-cross detection, evaluated only on sample_strobe: zc = (sample == 0) || (sample[15] != prev_sample[15]). prev_sample updates on every strobe.
- Each channel runs an independent, identical FSM.
  - IDLE: when attenuation != eff_target, go to WAIT_ZC with zc_cnt = 0. No step is taken in this cycle.
  - WAIT_ZC: if attenuation == eff_target (target changed back), go to IDLE and pulse ramp_done. Otherwise, on sample_strobe:
    - if zc, or zc_cnt == ZC_TIMEOUT-1: attenuation moves ±1 toward eff_target, registered so the new value is visible the next cycle. Go to HOLD with hold_cnt = 0.
    - else increment zc_cnt.
  - HOLD: on sample_strobe, increment hold_cnt. When hold_cnt == STEP_DIV-1:
    - if attenuation == eff_target, go to IDLE and pulse ramp_done in the cycle IDLE is entered;
    - else go to WAIT_ZC with zc_cnt = 0.
- Step direction is recomputed at every step from the current eff_target. A mid-ramp reversal therefore reverses immediately on the next step, with no overshoot.
- attenuation stays within 0..63 and never wraps.
- A target write during HOLD does not shorten the hold.
- Mute set mid-ramp ramps to 63. Clearing mute ramps back to the stored target.
- Writing the value the channel already has in IDLE causes no activity and no ramp_done.
- Cycles without sample_strobe never advance counters or attenuation.
- rst at any time: all state returns to reset values on the next edge. A ramp in progress is abandoned and the output jumps to 63.
- busy is combinational: (state_left != IDLE) || (state_right != IDLE).

Test Plan:
1. Reset, then write left target 60. Set STEP_DIV=4, ZC_TIMEOUT=8, drive constant +1000 on both inputs, strobe every 4 clk.
   -> left steps 63→62→61→60 on strobes 8, 20 and 32 after the write.
   -> ramp_done_left pulses once, after strobe 36.
   -> right stays 63; busy high for the whole interval.
2. With defaults, drive a 64-sample-period sine (amplitude 32767), one strobe per sample, and write right target 61.
   -> each of the two steps lands on a strobe with sign change or zero sample.
   -> steps are spaced by at least 16 strobes; no timeout-forced step occurs.
3. Left ramping 63→0 at attenuation 40: write mute=1 target 0.
   -> left ramps back up to 63, then ramp_done_left.
   -> write mute=0 → left ramps down to 0.
4. Target reversal: left ramping 63→50, at 55 write target 58.
   -> sequence continues 55→56→57→58 with no value below 55, then ramp_done_left.
5. Assert rst for one cycle at left attenuation 45 during WAIT_ZC.
   -> next cycle attenuation_left = 63, busy = 0, ramp_done_* = 0, and no further steps occur.
6. reg_wr (left, target 62) in the same cycle as a zero-crossing sample_strobe while left is IDLE at 63.
   -> no step on that strobe.
   -> FSM enters WAIT_ZC the next cycle and the step occurs on a later strobe.
